// File: rtl/mac_sequencer.sv
// MAC sequencer: walks the x/w buffers for one dot product and
// drives the MAC strobes, then hands the result downstream.
package mac_pkg;
  localparam int Q_INT  = 8;
  localparam int Q_FRAC = 8;
  localparam int Q_SIZE = Q_INT + Q_FRAC;
endpackage

module mac_sequencer
  import mac_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [LEN_W-1:0]         i_len,
  input  logic [ADDR_W-1:0]        i_x_base,
  input  logic [ADDR_W-1:0]        i_w_base,
  output logic                     o_busy,
  output logic                     o_rd_en,
  output logic [ADDR_W-1:0]        o_x_addr,
  output logic [ADDR_W-1:0]        o_w_addr,
  output logic                     o_mac_acc_loopback,
  output logic                     o_mac_acc_update,
  input  logic signed [Q_SIZE-1:0] i_mac,
  output logic signed [Q_SIZE-1:0] o_result,
  output logic                     o_result_valid,
  input  logic                     i_result_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                   r_state;
  logic [LEN_W-1:0]         r_i;
  logic [LEN_W-1:0]         r_last;
  logic                     r_rd_en;
  logic                     r_nz;
  logic                     r_upd;
  logic                     r_loop;
  logic                     r_valid;
  logic [ADDR_W-1:0]        r_x_addr;
  logic [ADDR_W-1:0]        r_w_addr;
  logic signed [Q_SIZE-1:0] r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_last   <= '0;
      r_rd_en  <= 1'b0;
      r_nz     <= 1'b0;
      r_upd    <= 1'b0;
      r_loop   <= 1'b0;
      r_valid  <= 1'b0;
      r_x_addr <= '0;
      r_w_addr <= '0;
      r_result <= '0;
    end else begin
      // strobes trail the read by one cycle, matching read latency
      r_upd  <= r_rd_en;
      r_loop <= r_rd_en & r_nz;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              r_state  <= S_FETCH;
              r_rd_en  <= 1'b1;
              r_nz     <= 1'b0;
              r_i      <= '0;
              r_last   <= i_len - 1'b1;
              r_x_addr <= i_x_base;
              r_w_addr <= i_w_base;
            end else begin
              r_result <= '0;
              r_valid  <= 1'b1;
              r_state  <= S_OUT;
            end
          end
        end
        S_FETCH: begin
          if (r_i == r_last) begin
            r_rd_en <= 1'b0;
            r_nz    <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_i      <= r_i + 1'b1;
            r_nz     <= 1'b1;
            r_x_addr <= r_x_addr + 1'b1;
            r_w_addr <= r_w_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          r_result <= i_mac;
          r_valid  <= 1'b1;
          r_state  <= S_OUT;
        end
        S_OUT: begin
          if (i_result_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy             = (r_state != S_IDLE);
  assign o_rd_en            = r_rd_en;
  assign o_x_addr           = r_x_addr;
  assign o_w_addr           = r_w_addr;
  assign o_mac_acc_loopback = r_loop;
  assign o_mac_acc_update   = r_upd;
  assign o_result           = r_result;
  assign o_result_valid     = r_valid;

endmodule
